// File: rtl/mtr_drv.sv
// Dual-channel H-bridge PWM driver with period-aligned duty latching and dead-time on reversal.
// Optional dynamic brake on zero duty: define MTR_DRV_BRAKE_EN.
module mtr_drv #(
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] lft_spd,
    input  logic        lft_rev,
    input  logic [10:0] rght_spd,
    input  logic        rght_rev,
    output logic        PWM_frwrd_lft,
    output logic        PWM_rev_lft,
    output logic        PWM_frwrd_rght,
    output logic        PWM_rev_rght,
    output logic        lft_dead,
    output logic        rght_dead
);

    typedef enum logic [1:0] {COAST, FWD, REV, DEAD} state_t;

    logic [10:0] cnt_q, cnt_d;
    logic        boundary;

    // Index 0 is the left channel, index 1 the right channel.
    logic [10:0] spd       [2];
    logic        rev_in    [2];
    state_t      state_q   [2];
    state_t      state_d   [2];
    logic [10:0] duty_q    [2];
    logic [10:0] duty_d    [2];
    logic [2:0]  dcnt_q    [2];
    logic [2:0]  dcnt_d    [2];
    logic        frwrd_q   [2];
    logic        frwrd_d   [2];
    logic        rvs_q     [2];
    logic        rvs_d     [2];

    assign spd[0]    = lft_spd;
    assign spd[1]    = rght_spd;
    assign rev_in[0] = lft_rev;
    assign rev_in[1] = rght_rev;
    assign boundary  = (cnt_q == 11'h7FF);

    always_comb begin
        cnt_d = cnt_q + 11'd1;
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            duty_d[ch]  = duty_q[ch];
            dcnt_d[ch]  = dcnt_q[ch];
            frwrd_d[ch] = 1'b0;
            rvs_d[ch]   = 1'b0;

            if (boundary) begin
                duty_d[ch] = spd[ch];
            end

            // Enable loss is immediate; everything else waits for the period boundary.
            if (!en) begin
                state_d[ch] = COAST;
                dcnt_d[ch]  = 3'd0;
            end else if (boundary) begin
                case (state_q[ch])
                    COAST: state_d[ch] = rev_in[ch] ? REV : FWD;
                    FWD: begin
                        if (rev_in[ch]) begin
                            state_d[ch] = DEAD;
                            dcnt_d[ch]  = 3'(DEAD_PERIODS);
                        end
                    end
                    REV: begin
                        if (!rev_in[ch]) begin
                            state_d[ch] = DEAD;
                            dcnt_d[ch]  = 3'(DEAD_PERIODS);
                        end
                    end
                    DEAD: begin
                        dcnt_d[ch] = dcnt_q[ch] - 3'd1;
                        if (dcnt_q[ch] == 3'd1) begin
                            state_d[ch] = rev_in[ch] ? REV : FWD;
                        end
                    end
                    default: state_d[ch] = COAST;
                endcase
            end

            // Drive lines are computed from next-cycle values so the flops line up with cnt_q.
            frwrd_d[ch] = (state_d[ch] == FWD) && (cnt_d < duty_d[ch]);
            rvs_d[ch]   = (state_d[ch] == REV) && (cnt_d < duty_d[ch]);
`ifdef MTR_DRV_BRAKE_EN
            if ((state_d[ch] == FWD || state_d[ch] == REV) && duty_d[ch] == 11'd0) begin
                frwrd_d[ch] = 1'b1;
                rvs_d[ch]   = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 11'd0;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= COAST;
                duty_q[ch]  <= 11'd0;
                dcnt_q[ch]  <= 3'd0;
                frwrd_q[ch] <= 1'b0;
                rvs_q[ch]   <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                duty_q[ch]  <= duty_d[ch];
                dcnt_q[ch]  <= dcnt_d[ch];
                frwrd_q[ch] <= frwrd_d[ch];
                rvs_q[ch]   <= rvs_d[ch];
            end
        end
    end

    assign PWM_frwrd_lft  = frwrd_q[0];
    assign PWM_rev_lft    = rvs_q[0];
    assign PWM_frwrd_rght = frwrd_q[1];
    assign PWM_rev_rght   = rvs_q[1];
    assign lft_dead       = (state_q[0] == DEAD);
    assign rght_dead      = (state_q[1] == DEAD);

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Consumes the per-wheel speed/direction pair produced by the balance controller: 11-bit unsigned speed plus reverse flag, one pair per wheel.
- Generates the four H-bridge PWM drive lines: forward and reverse for each of the left and right motors.
- Latches duty only at PWM period boundaries, so no glitched periods occur.
- Enforces a dead-time interval of whole PWM periods on every direction reversal.

Parameters:
- DEAD_PERIODS, 2: number of full PWM periods with both lines of a channel low on a direction reversal; legal range 1..7.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset, sampled on posedge clk.
- en, input, 1: drive enable (pwr_up); low forces coast.
- lft_spd, input, 11: left duty magnitude, unsigned.
- lft_rev, input, 1: left direction, 1 = reverse.
- rght_spd, input, 11: right duty magnitude, unsigned.
- rght_rev, input, 1: right direction, 1 = reverse.
- PWM_frwrd_lft, output, 1: left forward drive.
- PWM_rev_lft, output, 1: left reverse drive.
- PWM_frwrd_rght, output, 1: right forward drive.
- PWM_rev_rght, output, 1: right reverse drive.
- lft_dead, output, 1: high while the left channel is in its dead interval.
- rght_dead, output, 1: high while the right channel is in its dead interval.

Behaviour:
- Reset:
  - Synchronous: while rst_n = 0 at posedge, all outputs are 0, the PWM counter is 0, latched duties are 0, both FSMs are in COAST and the dead counters are 0.
- PWM counter:
  - Shared 11-bit free-running counter cnt, incrementing every clk and wrapping 2047 -> 0. Period = 2048 clocks.
- Boundary event:
  - Defined as the cycle where cnt == 2047.
  - At that edge each channel latches duty <= spd and dir <= rev, and its FSM evaluates its transition.
  - New duty and direction take effect from cnt == 0. Input-to-output latency is therefore 1..2048 clocks.
  - Inputs are ignored at all other cycles.
- Active line:
  - pwm_raw = (cnt < duty), registered, so outputs are glitch-free flop outputs.
  - duty = 0 gives a line that is always low. duty = 0x7FF gives 2047 high clocks out of 2048.
- Per-channel FSM. States COAST, FWD, REV, DEAD.
  - COAST: both lines 0. At a boundary with en = 1, go to REV if rev = 1, else FWD. No dead time is needed from COAST.
  - FWD: frwrd = pwm_raw, rev line = 0. At a boundary with rev = 1, go to DEAD and load dead_cnt = DEAD_PERIODS.
  - REV: mirror of FWD; go to DEAD on a boundary with rev = 0.
  - DEAD: both lines 0 and deadflag = 1. dead_cnt decrements at each boundary. At the boundary where it reaches 0, go to the direction given by the rev value latched at that boundary.
    - If rev toggles back during DEAD, the full dead interval is still served. Leaving DEAD means entering the direction present at exit; DEAD is never aborted early.
- Enable:
  - en = 0 at any cycle: the next posedge forces both FSMs to COAST and all PWM lines to 0, immediately and not waiting for a boundary. The dead counter clears.
  - When en returns, channels leave COAST at the next boundary.
- Channel independence: left and right FSMs are independent. Both may be in DEAD simultaneously.
- Invariant: the frwrd and rev lines of one channel are never high in the same cycle. This holds under all inputs, including reset mid-period and en dropping mid-period.
- Reset mid-operation:
  - Outputs are 0 from the first reset edge.
  - After release the counter restarts at 0, so the first boundary is 2048 clocks later.

Optional Feature:
- Macro MTR_DRV_BRAKE_EN.
- Defined: in FWD or REV with latched duty == 0, both lines of that channel are driven 1 (dynamic brake). This applies for the whole period.
  - DEAD and COAST still drive both lines 0.
  - The mutual-exclusion invariant is relaxed only for this brake case.
- Undefined: duty 0 gives both lines 0 (coast). The invariant holds unconditionally.

Test Plan:
- Reset release, en = 1, lft_spd = 0x400, lft_rev = 0:
  - All outputs stay 0 until cnt wraps.
  - Then PWM_frwrd_lft is high exactly 1024 of 2048 clocks per period; PWM_rev_lft stays 0.
- FWD at spd 0x200, then lft_rev -> 1 mid-period, DEAD_PERIODS = 2:
  - The current period completes normally.
  - Then 2 x 2048 clocks follow with both lines low and lft_dead = 1.
  - Then PWM_rev_lft runs at 512/2048.
- spd = 0x7FF: high 2047 clocks and low 1 clock per period.
- spd = 0: line constantly low.
  - With MTR_DRV_BRAKE_EN defined, both lines are constantly high in FWD.
- Change lft_spd 0x100 -> 0x600 at cnt = 100: the current period keeps its 256-clock pulse, and the next period has a 1536-clock pulse.
- en dropped at cnt = 50 while both channels are active:
  - All four PWM lines are 0 at the next edge and both FSMs are in COAST.
  - After en is restored, driving resumes at the first boundary with no dead interval.
- Synchronous reset asserted mid-pulse at cnt = 300:
  - Outputs are 0 on that edge.
  - An assertion checks that frwrd & rev is never 1 for either channel over 10^6 random-input cycles (brake macro undefined).
